wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage of the RV32I pipeline; sits between the MEM stage / data memory and the register file.
//  Holds one retiring instruction and waits for the load response when needed.
//  Formats load data (byte/half, signed/unsigned), then drives the register-file write port.
//  Also exports the same result as a forwarding source and counts retired instructions.
// PARAMETERS
//  XLEN   32  datapath width
//  CNT_W  32  width of retire counter
// PORTS
//  clk             in   1      clock
//  reset           in   1      asynchronous, active-high reset
//  in_valid        in   1      MEM stage presents an instruction
//  in_ready        out  1      stage can accept this cycle
//  in_rd           in   5      destination register
//  in_wb_sel       in   2      00 ALU, 01 LOAD, 10 PC+4, 11 treated as ALU
//  in_funct3       in   3      load width/sign (used only for LOAD)
//  in_alu_result   in   XLEN   ALU result / load byte address
//  in_pc_plus4     in   XLEN   link value
//  dmem_rvalid     in   1      load response valid (single-cycle pulse)
//  dmem_rdata      in   XLEN   aligned 32-bit word containing the load data
//  rf_write_en     out  1      register-file write enable
//  rf_write_addr   out  5      register-file write address
//  rf_write_value  out  XLEN   register-file write data
//  fwd_valid       out  1      forwarding source valid (= rf_write_en)
//  retire_count    out  CNT_W  instructions retired since reset
//  err_misaligned  out  1      sticky: misaligned or illegal load seen
//  err_unexp_rsp   out  1      sticky: dmem_rvalid outside WAIT_LOAD
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0 except in_ready=1. Held rd/sel/funct3/data regs cleared.
//  States:
//   IDLE: in_ready=1. Accept -> WAIT_LOAD if wb_sel=01, else WRITE.
//   WAIT_LOAD: in_ready=0. dmem_rvalid -> latch formatted data, go to WRITE.
//   WRITE: result held. rf_write_en=(rd!=0), so the write commits at the next edge.
//     in_ready=1. Accept -> WAIT_LOAD/WRITE per new wb_sel; else -> IDLE.
//  Accepting: captured at the edge when in_valid && in_ready.
//  Latency: non-load accepted at edge N -> write committed at edge N+1.
//   Load with response at edge K -> write committed at edge K+1.
//   Back-to-back non-loads sustain 1 instr/cycle.
//  Value selection: ALU -> in_alu_result; PC+4 -> in_pc_plus4; LOAD -> formatted dmem_rdata.
//  Load format (off = alu_result[1:0], captured at accept):
//   LB/LBU (000/100): byte at dmem_rdata[8*off +: 8], sign/zero-extended.
//   LH/LHU (001/101): half at [16*off[1] +: 16]; off[0]=1 is misaligned.
//   LW (010): full word; off!=0 is misaligned.
//   Misaligned or any other funct3: value 0, err_misaligned set; the write still occurs (rd!=0).
//  rd=0: rf_write_en and fwd_valid stay 0 in WRITE, but the instruction still retires.
//  rf_write_addr/value are driven from registers (no combinational path from inputs); they are 0 outside WRITE.
//  retire_count: +1 every cycle in WRITE; wraps modulo 2^CNT_W.
//  dmem_rvalid in IDLE or WRITE: ignored for data; err_unexp_rsp set.
//  dmem_rvalid in the same cycle as in_valid while in WAIT_LOAD: response consumed; in_valid not accepted (in_ready=0).
//  Sticky errors clear only on reset.
//  Reset mid-load: pending load dropped, no write; a later stray response sets err_unexp_rsp.
// TESTING
//  1. ALU op rd=5, result 0x1234 at edge 0 -> cycle 1: rf_write_en=1, addr=5, value=0x1234; retire_count=1 after edge 1.
//  2. LB, addr ...3, rdata 0x80FF_0000, rvalid 3 cycles later -> in_ready=0 while waiting; writes 0xFFFF_FF80. LBU -> 0x0000_0080.
//  3. LH at off=2, rdata 0x8001_xxxx -> 0xFFFF_8001; LH at off=1 -> value 0, err_misaligned=1.
//  4. Stream 4 ALU ops (rd 1..4), in_valid held high -> 4 consecutive write cycles; in_ready stays 1; retire_count=4.
//  5. JAL rd=0, pc_plus4=0x104 -> no write, fwd_valid=0, retire_count increments.
//  6. Reset asserted during WAIT_LOAD, then rvalid -> outputs 0 immediately, no write, err_unexp_rsp=1.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for a load response when
// needed, formats load data and drives the register-file write / forwarding port.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wb_sel,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_pc_plus4,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             rf_write_en,
    output logic [4:0]       rf_write_addr,
    output logic [XLEN-1:0]  rf_write_value,
    output logic             fwd_valid,
    output logic [CNT_W-1:0] retire_count,
    output logic             err_misaligned,
    output logic             err_unexp_rsp
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_LOAD = 2'd1;
    localparam logic [1:0] ST_WRITE     = 2'd2;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [1:0]       r_state;
    logic [4:0]       r_rd;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic [XLEN-1:0]  r_value;
    logic [CNT_W-1:0] r_retire;
    logic             r_errMisaligned;
    logic             r_errUnexp;

    logic             w_accept;
    logic             w_isLoad;
    logic             w_inWrite;
    logic             w_rspTaken;
    logic [XLEN-1:0]  w_directValue;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [XLEN-1:0]  w_loadValue;
    logic             w_loadBad;

    // A pending load blocks new work; a response in the same cycle is consumed first.
    assign in_ready      = (r_state != ST_WAIT_LOAD);
    assign w_accept      = in_valid && in_ready;
    assign w_isLoad      = (in_wb_sel == SEL_LOAD);
    assign w_inWrite     = (r_state == ST_WRITE);
    assign w_rspTaken    = (r_state == ST_WAIT_LOAD) && dmem_rvalid;
    assign w_directValue = (in_wb_sel == SEL_PC4) ? in_pc_plus4 : in_alu_result;

    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (r_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    end

    // Misaligned or unknown widths still retire and write, but with a zero value.
    always_comb begin
        w_loadValue = '0;
        w_loadBad   = 1'b0;
        case (r_funct3)
            F3_LB:  w_loadValue = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU: w_loadValue = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH: begin
                if (r_off[0]) begin
                    w_loadBad = 1'b1;
                end else begin
                    w_loadValue = {{(XLEN-16){w_half[15]}}, w_half};
                end
            end
            F3_LHU: begin
                if (r_off[0]) begin
                    w_loadBad = 1'b1;
                end else begin
                    w_loadValue = {{(XLEN-16){1'b0}}, w_half};
                end
            end
            F3_LW: begin
                if (r_off != 2'd0) begin
                    w_loadBad = 1'b1;
                end else begin
                    w_loadValue = dmem_rdata;
                end
            end
            default: w_loadBad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= w_isLoad ? ST_WAIT_LOAD : ST_WRITE;
                    end
                end
                ST_WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_accept) begin
                        r_state <= w_isLoad ? ST_WAIT_LOAD : ST_WRITE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd     <= '0;
            r_funct3 <= '0;
            r_off    <= '0;
        end else if (w_accept) begin
            r_rd     <= in_rd;
            r_funct3 <= in_funct3;
            r_off    <= in_alu_result[1:0];
        end
    end

    // Accept and response are mutually exclusive, so one register holds either result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (w_accept) begin
            r_value <= w_directValue;
        end else if (w_rspTaken) begin
            r_value <= w_loadValue;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire        <= '0;
            r_errMisaligned <= 1'b0;
            r_errUnexp      <= 1'b0;
        end else begin
            if (w_inWrite) begin
                r_retire <= r_retire + CNT_W'(1);
            end
            if (w_rspTaken && w_loadBad) begin
                r_errMisaligned <= 1'b1;
            end
            if (dmem_rvalid && (r_state != ST_WAIT_LOAD)) begin
                r_errUnexp <= 1'b1;
            end
        end
    end

    assign rf_write_en    = w_inWrite && (r_rd != 5'd0);
    assign fwd_valid      = rf_write_en;
    assign rf_write_addr  = w_inWrite ? r_rd : 5'd0;
    assign rf_write_value = w_inWrite ? r_value : '0;
    assign retire_count   = r_retire;
    assign err_misaligned = r_errMisaligned;
    assign err_unexp_rsp  = r_errUnexp;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for the documented scenarios.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [1:0]  in_wb_sel = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_pc_plus4 = '0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        rf_write_en;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_value;
    logic        fwd_valid;
    logic [31:0] retire_count;
    logic        err_misaligned;
    logic        err_unexp_rsp;

    int nCompared = 0;
    int nMismatched = 0;

    wb_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_rd(in_rd),
        .in_wb_sel(in_wb_sel),
        .in_funct3(in_funct3),
        .in_alu_result(in_alu_result),
        .in_pc_plus4(in_pc_plus4),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .rf_write_en(rf_write_en),
        .rf_write_addr(rf_write_addr),
        .rf_write_value(rf_write_value),
        .fwd_valid(fwd_valid),
        .retire_count(retire_count),
        .err_misaligned(err_misaligned),
        .err_unexp_rsp(err_unexp_rsp)
    );

    always #5 clk = ~clk;

    // Load formatting from the ISA rules: shift the word down, then extend.
    function automatic logic [31:0] loadValue(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
        logic [31:0] s;
        byte         sb;
        shortint     sh;
        s  = w >> (8 * off);
        sb = s[7:0];
        sh = s[15:0];
        case (f3)
            3'b000:  return int'(sb);
            3'b100:  return {24'd0, s[7:0]};
            3'b001:  return (off % 2 != 0) ? 32'd0 : int'(sh);
            3'b101:  return (off % 2 != 0) ? 32'd0 : {16'd0, s[15:0]};
            3'b010:  return (off != 0) ? 32'd0 : w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic loadBad(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return (off % 2 != 0);
            3'b010:         return (off != 0);
            default:        return 1'b1;
        endcase
    endfunction

    // Model: at most one load outstanding, at most one instruction retiring.
    logic        mBusy, mWr, mErrMis, mErrUnexp;
    logic [4:0]  mLdRd, mWrRd;
    logic [2:0]  mLdF3;
    logic [1:0]  mLdOff;
    logic [31:0] mWrVal, mRetire;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusy <= 0; mWr <= 0; mErrMis <= 0; mErrUnexp <= 0;
            mLdRd <= 0; mWrRd <= 0; mLdF3 <= 0; mLdOff <= 0;
            mWrVal <= 0; mRetire <= 0;
        end else begin
            if (mWr) mRetire <= mRetire + 1;
            if (dmem_rvalid && !mBusy) mErrUnexp <= 1;
            mWr <= 0;
            if (mBusy) begin
                if (dmem_rvalid) begin
                    mBusy  <= 0;
                    mWr    <= 1;
                    mWrRd  <= mLdRd;
                    mWrVal <= loadValue(mLdF3, mLdOff, dmem_rdata);
                    if (loadBad(mLdF3, mLdOff)) mErrMis <= 1;
                end
            end else if (in_valid) begin
                if (in_wb_sel == 2'b01) begin
                    mBusy  <= 1;
                    mLdRd  <= in_rd;
                    mLdF3  <= in_funct3;
                    mLdOff <= in_alu_result[1:0];
                end else begin
                    mWr    <= 1;
                    mWrRd  <= in_rd;
                    mWrVal <= (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [73:0] got, exp;
        got = {in_ready, rf_write_en, rf_write_addr, rf_write_value, fwd_valid,
               retire_count, err_misaligned, err_unexp_rsp};
        exp = {!mBusy, mWr && (mWrRd != 0), mWr ? mWrRd : 5'd0, mWr ? mWrVal : 32'd0,
               mWr && (mWrRd != 0), mRetire, mErrMis, mErrUnexp};
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL cycle t=%0t got rdy/en/addr/val/fwd/cnt/em/eu=%b/%b/%0d/%h/%b/%0d/%b/%b required %b/%b/%0d/%h/%b/%0d/%b/%b",
                     $time, got[73], got[72], got[71:67], got[66:35], got[34], got[33:2], got[1], got[0],
                     exp[73], exp[72], exp[71:67], exp[66:35], exp[34], exp[33:2], exp[1], exp[0]);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s got %h required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                                 input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                                 input logic rv, input logic [31:0] rdata);
        @(negedge clk);
        in_valid = v; in_rd = rd; in_wb_sel = sel; in_funct3 = f3;
        in_alu_result = alu; in_pc_plus4 = pc4; dmem_rvalid = rv; dmem_rdata = rdata;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [2:0]  tF3   [10] = '{3'b000, 3'b100, 3'b000, 3'b000, 3'b001, 3'b101, 3'b001, 3'b001, 3'b010, 3'b011};
    logic [1:0]  tOff  [10] = '{2'd3,   2'd3,   2'd2,   2'd1,   2'd2,   2'd2,   2'd0,   2'd1,   2'd3,   2'd0};
    logic [31:0] tData [10] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h8001_1234, 32'h8001_1234,
                                32'h8001_1234, 32'h8001_1234, 32'h8001_1234, 32'h8001_1234, 32'h8001_1234};
    logic [31:0] tExp  [10] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFFF, 32'h0000_0012, 32'hFFFF_8001,
                                32'h0000_8001, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset wen", {31'd0, rf_write_en}, 32'd0);
        checkOutput("reset count", retire_count, 32'd0);
        reset = 1'b0;

        // Single ALU op.
        applyStimulus(1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 0, 0);
        idleCycle();
        checkOutput("alu wen", {31'd0, rf_write_en}, 32'd1);
        checkOutput("alu addr", {27'd0, rf_write_addr}, 32'd5);
        checkOutput("alu value", rf_write_value, 32'h0000_1234);
        idleCycle();
        checkOutput("alu count", retire_count, 32'd1);

        // LB with a slow response.
        applyStimulus(1, 5'd7, 2'b01, 3'b000, 32'h0000_1003, 32'h0, 0, 0);
        idleCycle();
        checkOutput("lb wait ready", {31'd0, in_ready}, 32'd0);
        idleCycle();
        checkOutput("lb wait ready2", {31'd0, in_ready}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000);
        idleCycle();
        checkOutput("lb wen", {31'd0, rf_write_en}, 32'd1);
        checkOutput("lb addr", {27'd0, rf_write_addr}, 32'd7);
        checkOutput("lb value", rf_write_value, 32'hFFFF_FF80);

        // Table of load formats, including misaligned and illegal widths.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 5'd9, 2'b01, tF3[i], {30'h400, tOff[i]}, 32'h0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 1, tData[i]);
            idleCycle();
            checkOutput($sformatf("load%0d value", i), rf_write_value, tExp[i]);
            if (i == 6) checkOutput("no err yet", {31'd0, err_misaligned}, 32'd0);
        end
        checkOutput("err_misaligned", {31'd0, err_misaligned}, 32'd1);

        // Response and new instruction in the same cycle while waiting.
        applyStimulus(1, 5'd11, 2'b01, 3'b010, 32'h0000_2000, 32'h0, 0, 0);
        applyStimulus(1, 5'd12, 2'b00, 3'b000, 32'h0000_0055, 32'h0, 1, 32'hCAFE_F00D);
        applyStimulus(1, 5'd12, 2'b00, 3'b000, 32'h0000_0055, 32'h0, 0, 0);
        checkOutput("collide load value", rf_write_value, 32'hCAFE_F00D);
        idleCycle();
        checkOutput("collide alu addr", {27'd0, rf_write_addr}, 32'd12);
        checkOutput("collide alu value", rf_write_value, 32'h0000_0055);

        // Streaming ALU ops.
        resetDut();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 5'(i), 2'b00, 3'b000, 32'h100 + i, 32'h0, 0, 0);
            checkOutput("stream ready", {31'd0, in_ready}, 32'd1);
            if (i > 1) checkOutput("stream addr", {27'd0, rf_write_addr}, 32'(i - 1));
        end
        idleCycle();
        checkOutput("stream last addr", {27'd0, rf_write_addr}, 32'd4);
        idleCycle();
        checkOutput("stream count", retire_count, 32'd4);

        // JAL to x0 retires without writing.
        applyStimulus(1, 5'd0, 2'b10, 3'b000, 32'h0, 32'h0000_0104, 0, 0);
        idleCycle();
        checkOutput("jal0 wen", {31'd0, rf_write_en}, 32'd0);
        checkOutput("jal0 fwd", {31'd0, fwd_valid}, 32'd0);
        idleCycle();
        checkOutput("jal0 count", retire_count, 32'd5);

        // Reset in the middle of a load, then a stray response.
        applyStimulus(1, 5'd13, 2'b01, 3'b000, 32'h0, 32'h0, 0, 0);
        idleCycle();
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midreset count", retire_count, 32'd0);
        checkOutput("midreset value", rf_write_value, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
        idleCycle();
        checkOutput("stray err_unexp", {31'd0, err_unexp_rsp}, 32'd1);
        checkOutput("stray wen", {31'd0, rf_write_en}, 32'd0);
        idleCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
